// File: rtl/i2c_rtc_target.sv
// I2C target that emulates the DS1340 RTC register map: eight byte registers behind a shared,
// auto-incrementing pointer, plus a local update port for an on-chip timekeeper.
module i2c_rtc_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h68,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    input  logic       upd_en,
    input  logic [2:0] upd_addr,
    input  logic [7:0] upd_data,
    output logic [7:0] rtc_sec,
    output logic [7:0] rtc_min,
    output logic [7:0] rtc_hour,
    output logic [7:0] rtc_week,
    output logic [7:0] rtc_day,
    output logic [7:0] rtc_mon,
    output logic [7:0] rtc_year,
    output logic [7:0] rtc_ctrl,
    output logic       wr_pulse,
    output logic [2:0] wr_addr,
    output logic       busy
);

    localparam int unsigned    CntW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAddr   = 3'd1,
        StPtr    = 3'd2,
        StWdata  = 3'd3,
        StRdata  = 3'd4,
        StIgnore = 3'd5
    } state_e;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      filt;
    logic [1:0]      filt_prev;
    logic [CntW-1:0] fcnt [2];

    state_e     state;
    logic [3:0] bit_cnt;
    logic [7:0] sh;
    logic [2:0] ptr;
    logic [7:0] regs [8];

    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_ev;
    logic       stop_ev;
    logic [7:0] rx_byte;

    // A level is accepted only after FILT_LEN consecutive synchronized samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            filt      <= 2'b11;
            filt_prev <= 2'b11;
            fcnt[0]   <= '0;
            fcnt[1]   <= '0;
        end else begin
            sync1     <= {i2c_sda_in, i2c_scl_in};
            sync2     <= sync1;
            filt_prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CntMax) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CntW'(1);
                end
            end
        end
    end

    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise = scl_f & ~filt_prev[0];
    assign scl_fall = ~scl_f & filt_prev[0];
    assign start_ev = scl_f & filt_prev[0] & filt_prev[1] & ~sda_f;
    assign stop_ev  = scl_f & filt_prev[0] & ~filt_prev[1] & sda_f;
    assign rx_byte  = {sh[6:0], sda_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            bit_cnt    <= 4'd0;
            sh         <= 8'h00;
            ptr        <= 3'd0;
            i2c_sda_oe <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr    <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == 7) ? 8'h80 : 8'h00;
            end
        end else begin
            wr_pulse <= 1'b0;
            // The I2C commit below is a later assignment, so it wins on a same-address collision.
            if (upd_en) begin
                regs[upd_addr] <= upd_data;
            end
            if (start_ev) begin
                state      <= StAddr;
                bit_cnt    <= 4'd0;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b1;
            end else if (stop_ev) begin
                state      <= StIdle;
                bit_cnt    <= 4'd0;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    StIdle, StIgnore: begin
                    end
                    StAddr, StPtr, StWdata: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                sh <= rx_byte;
                            end
                            if (bit_cnt < 4'd9) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                            if (bit_cnt == 4'd7 && state == StPtr) begin
                                ptr <= rx_byte[2:0];
                            end
                            if (bit_cnt == 4'd7 && state == StWdata) begin
                                regs[ptr] <= rx_byte;
                                wr_pulse  <= 1'b1;
                                wr_addr   <= ptr;
                                ptr       <= ptr + 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                if (state == StAddr && sh[7:1] != DEV_ADDR) begin
                                    state <= StIgnore;
                                end else begin
                                    i2c_sda_oe <= 1'b1;
                                end
                            end else if (bit_cnt == 4'd9) begin
                                i2c_sda_oe <= 1'b0;
                                bit_cnt    <= 4'd0;
                                if (state == StAddr) begin
                                    if (sh[0]) begin
                                        // Byte snapshot: later updates cannot touch sh.
                                        state      <= StRdata;
                                        sh         <= regs[ptr];
                                        i2c_sda_oe <= ~regs[ptr][7];
                                        ptr        <= ptr + 3'd1;
                                    end else begin
                                        state <= StPtr;
                                    end
                                end else if (state == StPtr) begin
                                    state <= StWdata;
                                end
                            end
                        end
                    end
                    StRdata: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd9) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                            if (bit_cnt == 4'd8 && sda_f) begin
                                state      <= StIgnore;
                                i2c_sda_oe <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt != 4'd0 && bit_cnt < 4'd8) begin
                                sh         <= {sh[6:0], 1'b0};
                                i2c_sda_oe <= ~sh[6];
                            end else if (bit_cnt == 4'd8) begin
                                i2c_sda_oe <= 1'b0;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt    <= 4'd0;
                                sh         <= regs[ptr];
                                i2c_sda_oe <= ~regs[ptr][7];
                                ptr        <= ptr + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state      <= StIdle;
                        i2c_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rtc_sec  = regs[0];
    assign rtc_min  = regs[1];
    assign rtc_hour = regs[2];
    assign rtc_week = regs[3];
    assign rtc_day  = regs[4];
    assign rtc_mon  = regs[5];
    assign rtc_year = regs[6];
    assign rtc_ctrl = regs[7];

endmodule
